// File: rtl/dispatch_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : dispatch_ctrl
//  Purpose  : Dispatch-stage scheduler. Grants or stalls decoded instructions
//             against ROB / ALU-RS / LSQ credit counters and the physical
//             register free list. Issues zero-latency allocate strobes and
//             sequences HALT and post-flush recovery.
//  Revision : 1.0 - initial release
// ============================================================================
module dispatch_ctrl #(
    parameter int ROB_DEPTH   = 16,
    parameter int RS_DEPTH    = 8,
    parameter int LSQ_DEPTH   = 8,
    parameter int RECOVER_CYC = 2,
    parameter int STALL_W     = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               dec_valid,
    input  logic [5:0]         opcode,
    input  logic               isDispatch,
    input  logic               RegDest,
    input  logic               mem_ren,
    input  logic               mem_wen,
    input  logic               fl_empty,
    input  logic               rob_retire,
    input  logic               rs_release,
    input  logic               lsq_release,
    input  logic               flush,
    output logic               dec_ready,
    output logic               rob_alloc,
    output logic               rs_alloc,
    output logic               lsq_alloc,
    output logic               fl_pop,
    output logic               halted,
    output logic               credit_err,
    output logic [STALL_W-1:0] stall_cycles
);

    localparam int c_ROB_W = $clog2(ROB_DEPTH + 1);
    localparam int c_RS_W  = $clog2(RS_DEPTH + 1);
    localparam int c_LSQ_W = $clog2(LSQ_DEPTH + 1);
    localparam int c_REC_W = $clog2(RECOVER_CYC + 1);

    localparam logic [c_ROB_W-1:0] c_ROB_MAX  = c_ROB_W'(ROB_DEPTH);
    localparam logic [c_RS_W-1:0]  c_RS_MAX   = c_RS_W'(RS_DEPTH);
    localparam logic [c_LSQ_W-1:0] c_LSQ_MAX  = c_LSQ_W'(LSQ_DEPTH);
    localparam logic [c_REC_W-1:0] c_REC_INIT = c_REC_W'(RECOVER_CYC);
    localparam logic [c_REC_W-1:0] c_REC_ONE  = c_REC_W'(1);
    localparam logic [5:0]         c_OP_HALT  = 6'b110001;

    typedef enum logic [1:0] {
        S_RUN     = 2'd0,
        S_HALTED  = 2'd1,
        S_RECOVER = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic [c_REC_W-1:0]  r_rec_cnt;
    logic [c_REC_W-1:0]  w_rec_cnt_next;

    logic [c_ROB_W-1:0]  r_rob_cred;
    logic [c_RS_W-1:0]   r_rs_cred;
    logic [c_LSQ_W-1:0]  r_lsq_cred;
    logic [c_ROB_W-1:0]  w_rob_next;
    logic [c_RS_W-1:0]   w_rs_next;
    logic [c_LSQ_W-1:0]  w_lsq_next;

    logic                r_credit_err;
    logic [STALL_W-1:0]  r_stall;

    logic w_is_halt;
    logic w_mem;
    logic w_need_rob;
    logic w_need_rs;
    logic w_need_lsq;
    logic w_need_fl;
    logic w_ready;
    logic w_hs;
    logic w_rob_rel_ok;
    logic w_rs_rel_ok;
    logic w_lsq_rel_ok;
    logic w_err_set;

    // Resource needs; a HALT only ever takes a ROB entry
    always_comb begin
        w_is_halt  = isDispatch && (opcode == c_OP_HALT);
        w_mem      = mem_ren || mem_wen;
        w_need_rob = isDispatch;
        w_need_lsq = isDispatch && w_mem && !w_is_halt;
        w_need_rs  = isDispatch && !w_mem && !w_is_halt;
        w_need_fl  = isDispatch && RegDest && !w_is_halt;
    end

    // Accept only in RUN with every needed resource available; flush and reset win
    always_comb begin
        w_ready = !rst && (r_state == S_RUN) && !flush
                  && (!w_need_rob || (r_rob_cred != '0))
                  && (!w_need_rs  || (r_rs_cred  != '0))
                  && (!w_need_lsq || (r_lsq_cred != '0))
                  && (!w_need_fl  || !fl_empty);
        w_hs      = dec_valid && w_ready;
        dec_ready = w_ready;
        rob_alloc = w_hs && w_need_rob;
        rs_alloc  = w_hs && w_need_rs;
        lsq_alloc = w_hs && w_need_lsq;
        fl_pop    = w_hs && w_need_fl;
    end

    // Credit next values: alloc and release cancel, a release at full is dropped
    always_comb begin
        w_rob_rel_ok = rob_retire  && (r_rob_cred != c_ROB_MAX);
        w_rs_rel_ok  = rs_release  && (r_rs_cred  != c_RS_MAX);
        w_lsq_rel_ok = lsq_release && (r_lsq_cred != c_LSQ_MAX);
        w_err_set    = !flush && ((rob_retire  && !w_rob_rel_ok) ||
                                  (rs_release  && !w_rs_rel_ok)  ||
                                  (lsq_release && !w_lsq_rel_ok));

        w_rob_next = r_rob_cred;
        if (rob_alloc && !w_rob_rel_ok)
            w_rob_next = r_rob_cred - c_ROB_W'(1);
        else if (!rob_alloc && w_rob_rel_ok)
            w_rob_next = r_rob_cred + c_ROB_W'(1);

        w_rs_next = r_rs_cred;
        if (rs_alloc && !w_rs_rel_ok)
            w_rs_next = r_rs_cred - c_RS_W'(1);
        else if (!rs_alloc && w_rs_rel_ok)
            w_rs_next = r_rs_cred + c_RS_W'(1);

        w_lsq_next = r_lsq_cred;
        if (lsq_alloc && !w_lsq_rel_ok)
            w_lsq_next = r_lsq_cred - c_LSQ_W'(1);
        else if (!lsq_alloc && w_lsq_rel_ok)
            w_lsq_next = r_lsq_cred + c_LSQ_W'(1);
    end

    // Credit registers; a flush restores full capacity and ignores releases
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rob_cred <= c_ROB_MAX;
            r_rs_cred  <= c_RS_MAX;
            r_lsq_cred <= c_LSQ_MAX;
        end else if (flush) begin
            r_rob_cred <= c_ROB_MAX;
            r_rs_cred  <= c_RS_MAX;
            r_lsq_cred <= c_LSQ_MAX;
        end else begin
            r_rob_cred <= w_rob_next;
            r_rs_cred  <= w_rs_next;
            r_lsq_cred <= w_lsq_next;
        end
    end

    // Next-state logic: flush overrides everything and restarts recovery
    always_comb begin
        w_state_next   = r_state;
        w_rec_cnt_next = r_rec_cnt;
        if (flush) begin
            w_state_next   = S_RECOVER;
            w_rec_cnt_next = c_REC_INIT;
        end else begin
            case (r_state)
                S_RUN: begin
                    if (w_hs && w_is_halt)
                        w_state_next = S_HALTED;
                end
                S_HALTED: begin
                    w_state_next = S_HALTED;
                end
                S_RECOVER: begin
                    if (r_rec_cnt <= c_REC_ONE)
                        w_state_next = S_RUN;
                    else
                        w_rec_cnt_next = r_rec_cnt - c_REC_ONE;
                end
                default: begin
                    w_state_next = S_RUN;
                end
            endcase
        end
    end

    // State and recovery counter registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_RUN;
            r_rec_cnt <= '0;
        end else begin
            r_state   <= w_state_next;
            r_rec_cnt <= w_rec_cnt_next;
        end
    end

    // Sticky credit error and saturating stall counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_credit_err <= 1'b0;
            r_stall      <= '0;
        end else begin
            if (w_err_set)
                r_credit_err <= 1'b1;
            if ((r_state == S_RUN) && dec_valid && !w_ready && (r_stall != '1))
                r_stall <= r_stall + STALL_W'(1);
        end
    end

    assign halted       = (r_state == S_HALTED);
    assign credit_err   = r_credit_err;
    assign stall_cycles = r_stall;

endmodule
`default_nettype wire

// File: tb/tb_dispatch_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_dispatch_ctrl
//  Purpose  : Directed self-checking bench for dispatch_ctrl.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_dispatch_ctrl;

    localparam logic [5:0] c_OP_ADD  = 6'b000000;
    localparam logic [5:0] c_OP_LW   = 6'b100011;
    localparam logic [5:0] c_OP_SW   = 6'b101011;
    localparam logic [5:0] c_OP_HALT = 6'b110001;

    logic        clk = 1'b0;
    logic        rst;
    logic        dec_valid, isDispatch, RegDest, mem_ren, mem_wen, fl_empty;
    logic        rob_retire, rs_release, lsq_release, flush;
    logic [5:0]  opcode;
    logic        dec_ready, rob_alloc, rs_alloc, lsq_alloc, fl_pop;
    logic        halted, credit_err;
    logic [15:0] stall_cycles;

    int n_vec = 0;
    int n_err = 0;

    dispatch_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .dec_valid    (dec_valid),
        .opcode       (opcode),
        .isDispatch   (isDispatch),
        .RegDest      (RegDest),
        .mem_ren      (mem_ren),
        .mem_wen      (mem_wen),
        .fl_empty     (fl_empty),
        .rob_retire   (rob_retire),
        .rs_release   (rs_release),
        .lsq_release  (lsq_release),
        .flush        (flush),
        .dec_ready    (dec_ready),
        .rob_alloc    (rob_alloc),
        .rs_alloc     (rs_alloc),
        .lsq_alloc    (lsq_alloc),
        .fl_pop       (fl_pop),
        .halted       (halted),
        .credit_err   (credit_err),
        .stall_cycles (stall_cycles)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic idle_inputs();
        dec_valid = 0; isDispatch = 0; RegDest = 0; mem_ren = 0; mem_wen = 0;
        fl_empty = 0; rob_retire = 0; rs_release = 0; lsq_release = 0; flush = 0;
        opcode = c_OP_ADD;
    endtask

    task automatic pulse_reset();
        idle_inputs();
        rst = 1'b1;
        #1;
        rst = 1'b0;
    endtask

    task automatic drive(input logic [5:0] op, input logic rd, input logic ren, input logic wen);
        dec_valid = 1; isDispatch = 1; opcode = op; RegDest = rd; mem_ren = ren; mem_wen = wen;
    endtask

    initial begin
        idle_inputs();
        rst = 1'b1;
        #2;
        chk("rst_ready",  {31'd0, dec_ready},  32'd0);
        chk("rst_strobe", {28'd0, rob_alloc, rs_alloc, lsq_alloc, fl_pop}, 32'd0);
        chk("rst_halted", {31'd0, halted},     32'd0);
        chk("rst_err",    {31'd0, credit_err}, 32'd0);
        chk("rst_stall",  {16'd0, stall_cycles}, 32'd0);
        tick();
        rst = 1'b0;

        // 1: 16 back-to-back ADDs, RS runs out after 8
        drive(c_OP_ADD, 1, 0, 0);
        for (int i = 0; i < 16; i++) begin
            settle();
            chk("t1_ready",  {31'd0, dec_ready}, (i < 8) ? 32'd1 : 32'd0);
            chk("t1_rob",    {31'd0, rob_alloc}, (i < 8) ? 32'd1 : 32'd0);
            chk("t1_rs",     {31'd0, rs_alloc},  (i < 8) ? 32'd1 : 32'd0);
            chk("t1_fl",     {31'd0, fl_pop},    (i < 8) ? 32'd1 : 32'd0);
            chk("t1_stall",  {16'd0, stall_cycles}, (i < 8) ? 32'd0 : 32'(i - 8));
            tick();
        end

        // 2: RS release lets exactly one stalled ADD through
        rs_release = 1;
        settle();
        chk("t2_rel_ready", {31'd0, dec_ready}, 32'd0);
        chk("t2_stall8",    {16'd0, stall_cycles}, 32'd8);
        tick();
        rs_release = 0;
        settle();
        chk("t2_ready", {31'd0, dec_ready}, 32'd1);
        chk("t2_rs",    {31'd0, rs_alloc},  32'd1);
        chk("t2_stall9", {16'd0, stall_cycles}, 32'd9);
        tick();
        settle();
        chk("t2_rs_zero", {31'd0, dec_ready}, 32'd0);
        tick();

        // 3: 8 loads fill the LSQ, stores stall until release
        pulse_reset();
        drive(c_OP_LW, 1, 1, 0);
        for (int i = 0; i < 8; i++) begin
            settle();
            chk("t3_lw_lsq", {31'd0, lsq_alloc}, 32'd1);
            chk("t3_lw_rs",  {31'd0, rs_alloc},  32'd0);
            tick();
        end
        drive(c_OP_SW, 0, 0, 1);
        settle();
        chk("t3_sw_stall", {31'd0, dec_ready}, 32'd0);
        tick();
        lsq_release = 1;
        settle();
        chk("t3_rel_cycle", {31'd0, dec_ready}, 32'd0);
        tick();
        settle();
        chk("t3_sw_ready", {31'd0, dec_ready}, 32'd1);
        chk("t3_sw_lsq",   {31'd0, lsq_alloc}, 32'd1);
        chk("t3_sw_fl",    {31'd0, fl_pop},    32'd0);
        tick();
        lsq_release = 0;
        settle();
        chk("t3_same_cyc", {31'd0, lsq_alloc}, 32'd1);
        tick();
        settle();
        chk("t3_lsq_zero", {31'd0, dec_ready}, 32'd0);
        chk("t3_stall",    {16'd0, stall_cycles}, 32'd2);
        tick();

        // 4: HALT takes ROB only, then the front end is held off
        drive(c_OP_HALT, 0, 0, 0);
        settle();
        chk("t4_ready",  {31'd0, dec_ready}, 32'd1);
        chk("t4_rob",    {31'd0, rob_alloc}, 32'd1);
        chk("t4_rs",     {31'd0, rs_alloc},  32'd0);
        chk("t4_halt0",  {31'd0, halted},    32'd0);
        chk("t4_stall",  {16'd0, stall_cycles}, 32'd3);
        tick();
        drive(c_OP_ADD, 1, 0, 0);
        settle();
        chk("t4_halted", {31'd0, halted},    32'd1);
        chk("t4_hready", {31'd0, dec_ready}, 32'd0);
        chk("t4_hrob",   {31'd0, rob_alloc}, 32'd0);
        tick();
        settle();
        chk("t4_nostall", {16'd0, stall_cycles}, 32'd3);
        tick();
        flush = 1;
        settle();
        chk("t4_fl_ready", {31'd0, dec_ready}, 32'd0);
        tick();
        flush = 0;
        settle();
        chk("t4_unhalt", {31'd0, halted},    32'd0);
        chk("t4_rec1",   {31'd0, dec_ready}, 32'd0);
        tick();
        settle();
        chk("t4_rec2",   {31'd0, dec_ready}, 32'd0);
        tick();
        settle();
        chk("t4_run",    {31'd0, dec_ready}, 32'd1);
        tick();

        // 5: bring credits to ROB=3 / RS=1, flush during a valid ADD
        pulse_reset();
        drive(c_OP_ADD, 1, 0, 0);
        for (int i = 0; i < 7; i++) tick();
        drive(c_OP_LW, 1, 1, 0);
        for (int i = 0; i < 6; i++) tick();
        drive(c_OP_ADD, 1, 0, 0);
        flush = 1;
        settle();
        chk("t5_fl_ready",  {31'd0, dec_ready}, 32'd0);
        chk("t5_fl_strobe", {28'd0, rob_alloc, rs_alloc, lsq_alloc, fl_pop}, 32'd0);
        tick();
        flush = 0;
        for (int i = 0; i < 2; i++) begin
            settle();
            chk("t5_recover", {31'd0, dec_ready}, 32'd0);
            tick();
        end
        for (int i = 0; i < 9; i++) begin
            settle();
            chk("t5_add_rs", {31'd0, rs_alloc}, (i < 8) ? 32'd1 : 32'd0);
            if (i < 8) tick();
        end
        drive(c_OP_LW, 1, 1, 0);
        for (int i = 0; i < 9; i++) begin
            settle();
            chk("t5_lw", {31'd0, lsq_alloc}, (i < 8) ? 32'd1 : 32'd0);
            tick();
        end

        // 6: release at full sets sticky error; async reset clears all
        pulse_reset();
        rob_retire = 1;
        settle();
        chk("t6_err_pre", {31'd0, credit_err}, 32'd0);
        tick();
        rob_retire = 0;
        settle();
        chk("t6_err_set", {31'd0, credit_err}, 32'd1);
        drive(c_OP_ADD, 1, 0, 0);
        fl_empty = 1;
        settle();
        chk("t6_fl_empty", {31'd0, dec_ready}, 32'd0);
        tick();
        tick();
        settle();
        chk("t6_stall",    {16'd0, stall_cycles}, 32'd2);
        chk("t6_err_hold", {31'd0, credit_err},   32'd1);
        rst = 1'b1;
        #1;
        chk("t6_arst_stall", {16'd0, stall_cycles}, 32'd0);
        chk("t6_arst_err",   {31'd0, credit_err},   32'd0);
        chk("t6_arst_out",   {26'd0, dec_ready, rob_alloc, rs_alloc, lsq_alloc, fl_pop, halted}, 32'd0);
        rst = 1'b0;
        idle_inputs();
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
